// File: rtl/iomem_copy_master.sv
// iomem_copy_master: a bus initiator that copies a block of 32-bit words.
// For each word it reads from the source address and then writes that
// word to the destination address, over the iomem valid/ready bus.
// It reports a completion pulse, the number of words written, and a
// sticky error flag when a responder fails to answer in time.
module iomem_copy_master #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int LEN_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [31:0]          cmd_src,
  input  logic [31:0]          cmd_dst,
  input  logic [LEN_WIDTH-1:0] cmd_len,
  output logic                 done,
  output logic                 error,
  output logic [LEN_WIDTH-1:0] words_done,
  output logic                 busy,
  output logic                 iomem_valid,
  input  logic                 iomem_ready,
  output logic [3:0]           iomem_wstrb,
  output logic [31:0]          iomem_addr,
  output logic [31:0]          iomem_wdata,
  input  logic [31:0]          iomem_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  // The wait counter only ever needs to hold 0 .. TIMEOUT_CYCLES-1.
  localparam int            TW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  // Word addresses: the two low bits of the command addresses are dropped.
  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  logic [1:0]           state_reg, state_next;
  logic [31:0]          src_reg, src_next;
  logic [31:0]          dst_reg, dst_next;
  logic [LEN_WIDTH-1:0] len_reg, len_next;
  logic [LEN_WIDTH-1:0] words_done_reg, words_done_next;
  logic                 error_reg, error_next;
  logic                 done_reg, done_next;
  logic [TW-1:0]        to_cnt_reg, to_cnt_next;
  logic                 valid_reg, valid_next;
  logic [3:0]           wstrb_reg, wstrb_next;
  logic [31:0]          addr_reg, addr_next;
  logic [31:0]          wdata_reg, wdata_next;

  logic                 wait_expired;
  logic                 last_word;

  assign wait_expired = (to_cnt_reg == TO_LAST);
  assign last_word    = ((words_done_reg + LEN_WIDTH'(1)) == len_reg);

  // Next-state and next-output logic for the copy sequencer.
  always_comb begin
    state_next      = state_reg;
    src_next        = src_reg;
    dst_next        = dst_reg;
    len_next        = len_reg;
    words_done_next = words_done_reg;
    error_next      = error_reg;
    done_next       = 1'b0;
    to_cnt_next     = to_cnt_reg;
    valid_next      = valid_reg;
    wstrb_next      = wstrb_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;

    case (state_reg)
      S_IDLE: begin
        if (cmd_valid) begin
          src_next        = cmd_src & WORD_MASK;
          dst_next        = cmd_dst & WORD_MASK;
          len_next        = cmd_len;
          error_next      = 1'b0;
          words_done_next = '0;
          to_cnt_next     = '0;
          if (cmd_len == '0) begin
            // Nothing to move: report completion without touching the bus.
            state_next = S_FIN;
            done_next  = 1'b1;
          end else begin
            // Present the first read straight away from the registered outputs.
            state_next = S_RD;
            valid_next = 1'b1;
            wstrb_next = 4'h0;
            addr_next  = cmd_src & WORD_MASK;
          end
        end
      end

      S_RD: begin
        if (iomem_ready) begin
          // The write data register is loaded directly from the read data,
          // and the write request follows in the very next cycle.
          wdata_next  = iomem_rdata;
          src_next    = src_reg + 32'd4;
          to_cnt_next = '0;
          state_next  = S_WR;
          valid_next  = 1'b1;
          wstrb_next  = 4'hF;
          addr_next   = dst_reg;
        end else if (wait_expired) begin
          error_next  = 1'b1;
          valid_next  = 1'b0;
          to_cnt_next = '0;
          state_next  = S_FIN;
          done_next   = 1'b1;
        end else begin
          to_cnt_next = to_cnt_reg + TW'(1);
        end
      end

      S_WR: begin
        if (iomem_ready) begin
          dst_next        = dst_reg + 32'd4;
          words_done_next = words_done_reg + LEN_WIDTH'(1);
          to_cnt_next     = '0;
          if (last_word) begin
            state_next = S_FIN;
            done_next  = 1'b1;
            valid_next = 1'b0;
          end else begin
            // src_reg was already advanced when the read completed.
            state_next = S_RD;
            valid_next = 1'b1;
            wstrb_next = 4'h0;
            addr_next  = src_reg;
          end
        end else if (wait_expired) begin
          error_next  = 1'b1;
          valid_next  = 1'b0;
          to_cnt_next = '0;
          state_next  = S_FIN;
          done_next   = 1'b1;
        end else begin
          to_cnt_next = to_cnt_reg + TW'(1);
        end
      end

      S_FIN: begin
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
        valid_next = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      src_reg        <= '0;
      dst_reg        <= '0;
      len_reg        <= '0;
      words_done_reg <= '0;
      error_reg      <= 1'b0;
      done_reg       <= 1'b0;
      to_cnt_reg     <= '0;
      valid_reg      <= 1'b0;
      wstrb_reg      <= 4'h0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      src_reg        <= src_next;
      dst_reg        <= dst_next;
      len_reg        <= len_next;
      words_done_reg <= words_done_next;
      error_reg      <= error_next;
      done_reg       <= done_next;
      to_cnt_reg     <= to_cnt_next;
      valid_reg      <= valid_next;
      wstrb_reg      <= wstrb_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
    end
  end

  assign cmd_ready   = (state_reg == S_IDLE);
  assign busy        = (state_reg != S_IDLE);
  assign done        = done_reg;
  assign error       = error_reg;
  assign words_done  = words_done_reg;
  assign iomem_valid = valid_reg;
  assign iomem_wstrb = wstrb_reg;
  assign iomem_addr  = addr_reg;
  assign iomem_wdata = wdata_reg;

endmodule

// File: tb/tb_iomem_copy_master.sv
// Self-checking bench for iomem_copy_master. Instance A (default timeout)
// talks to a responder with programmable stall that returns the address as
// read data; instance B (TIMEOUT_CYCLES=8) talks to a responder that stops
// answering after a set number of transactions.
`timescale 1ns/1ps
module tb_iomem_copy_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] cmd_src;
  logic [31:0] cmd_dst;
  logic [15:0] cmd_len;

  logic        a_cmd_valid, a_cmd_ready, a_done, a_error, a_busy, a_valid;
  logic        a_ready = 1'b0;
  logic [15:0] a_words;
  logic [3:0]  a_wstrb;
  logic [31:0] a_addr, a_wdata;
  logic [31:0] a_rdata = 32'h0;

  logic        b_cmd_valid, b_cmd_ready, b_done, b_error, b_busy, b_valid;
  logic        b_ready = 1'b0;
  logic [15:0] b_words;
  logic [3:0]  b_wstrb;
  logic [31:0] b_addr, b_wdata;
  logic [31:0] b_rdata = 32'h0;

  int checks = 0;
  int errors = 0;

  iomem_copy_master u_dut_a (
    .clk(clk), .reset(reset),
    .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
    .done(a_done), .error(a_error), .words_done(a_words), .busy(a_busy),
    .iomem_valid(a_valid), .iomem_ready(a_ready), .iomem_wstrb(a_wstrb),
    .iomem_addr(a_addr), .iomem_wdata(a_wdata), .iomem_rdata(a_rdata)
  );

  iomem_copy_master #(.TIMEOUT_CYCLES(8)) u_dut_b (
    .clk(clk), .reset(reset),
    .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
    .done(b_done), .error(b_error), .words_done(b_words), .busy(b_busy),
    .iomem_valid(b_valid), .iomem_ready(b_ready), .iomem_wstrb(b_wstrb),
    .iomem_addr(b_addr), .iomem_wdata(b_wdata), .iomem_rdata(b_rdata)
  );

  // Responder A: answers after a_stall extra cycles, read data = address.
  int a_stall = 0;
  int a_wait_cnt = 0;
  always @(posedge clk) begin
    if (reset) begin
      a_ready    <= 1'b0;
      a_wait_cnt <= 0;
    end else if (a_ready) begin
      a_ready    <= 1'b0;
      a_wait_cnt <= 0;
    end else if (a_valid) begin
      if (a_wait_cnt >= a_stall) begin
        a_ready    <= 1'b1;
        a_rdata    <= a_addr;
        a_wait_cnt <= 0;
      end else begin
        a_wait_cnt <= a_wait_cnt + 1;
      end
    end
  end

  // Transaction log, pending-request stability monitor and event counters for A.
  logic [31:0] log_addr  [0:255];
  logic [3:0]  log_wstrb [0:255];
  logic [31:0] log_wdata [0:255];
  int          log_n = 0;
  int          stab_err = 0;
  int          stab_cycles = 0;
  int          a_valid_cycles = 0;
  int          a_done_total = 0;
  logic        pend = 1'b0;
  logic [31:0] h_addr = 32'h0;
  logic [31:0] h_wdata = 32'h0;
  logic [3:0]  h_wstrb = 4'h0;
  always @(posedge clk) begin
    if (a_done) a_done_total <= a_done_total + 1;
    if (a_valid) a_valid_cycles <= a_valid_cycles + 1;
    if (!reset && a_valid && a_ready && log_n < 256) begin
      log_addr[log_n]  <= a_addr;
      log_wstrb[log_n] <= a_wstrb;
      log_wdata[log_n] <= a_wdata;
      log_n            <= log_n + 1;
      $display("txn A addr=%08h wstrb=%h wdata=%08h rdata=%08h", a_addr, a_wstrb, a_wdata, a_rdata);
    end
    if (!reset && a_valid && pend) begin
      stab_cycles <= stab_cycles + 1;
      if (a_addr !== h_addr || a_wstrb !== h_wstrb || a_wdata !== h_wdata)
        stab_err <= stab_err + 1;
    end
    pend    <= a_valid && !a_ready && !reset;
    h_addr  <= a_addr;
    h_wstrb <= a_wstrb;
    h_wdata <= a_wdata;
  end

  // Responder B: 1-cycle latency for the first b_limit transactions, then silent.
  int b_limit = 0;
  int b_served = 0;
  int b_done_total = 0;
  always @(posedge clk) begin
    if (b_done) b_done_total <= b_done_total + 1;
    if (reset) begin
      b_ready  <= 1'b0;
      b_served <= 0;
    end else if (b_ready) begin
      b_ready <= 1'b0;
      $display("txn B addr=%08h wstrb=%h wdata=%08h rdata=%08h", b_addr, b_wstrb, b_wdata, b_rdata);
    end else if (b_valid && b_served < b_limit) begin
      b_ready  <= 1'b1;
      b_rdata  <= b_addr;
      b_served <= b_served + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one command for exactly one clock edge; returns 1ns after the accept edge.
  task automatic issue(input bit use_b, input logic [31:0] s, input logic [31:0] d,
                       input logic [15:0] n);
    cmd_src = s;
    cmd_dst = d;
    cmd_len = n;
    if (use_b) b_cmd_valid = 1'b1;
    else       a_cmd_valid = 1'b1;
    tick();
    a_cmd_valid = 1'b0;
    b_cmd_valid = 1'b0;
    $display("cmd %s src=%08h dst=%08h len=%0d", use_b ? "B" : "A", s, d, n);
  endtask

  // Waits for done on A; cyc = clock edges from the accept edge to the edge raising done.
  task automatic wait_done_a(input int limit, output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    while (cyc < limit) begin
      if (a_done) begin
        ok = 1'b1;
        break;
      end
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (a_cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b want 1", a_cmd_ready); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", a_busy); end
    checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", a_done); end
    checks++; if (a_error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b want 0", a_error); end
    checks++; if (a_words !== 16'd0) begin errors++; $display("FAIL reset_words: got %0d want 0", a_words); end
    checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", a_valid); end
    checks++; if (a_wstrb !== 4'h0) begin errors++; $display("FAIL reset_wstrb: got %h want 0", a_wstrb); end
    checks++; if (a_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", a_addr); end
    checks++; if (a_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h want 0", a_wdata); end
    checks++; if (b_cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_b_cmd_ready: got %b want 1", b_cmd_ready); end
    checks++; if (b_valid !== 1'b0) begin errors++; $display("FAIL reset_b_valid: got %b want 0", b_valid); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_copy3();
    int cyc, base, d0;
    bit ok;
    logic [31:0] exp_addr, exp_data;
    a_stall = 0;
    base = log_n;
    d0 = a_done_total;
    issue(1'b0, 32'h0300_0000, 32'h0300_0010, 16'd3);
    checks++; if (a_busy !== 1'b1 || a_cmd_ready !== 1'b0) begin errors++; $display("FAIL copy3_busy: got busy=%b ready=%b want 1/0", a_busy, a_cmd_ready); end
    wait_done_a(100, cyc, ok);
    checks++; if (!ok) begin errors++; $display("FAIL copy3_timeout: got no done want done within 100 cycles"); end
    checks++; if (cyc !== 12) begin errors++; $display("FAIL copy3_latency: got %0d want 12", cyc); end
    checks++; if (a_words !== 16'd3) begin errors++; $display("FAIL copy3_words: got %0d want 3", a_words); end
    checks++; if (a_error !== 1'b0) begin errors++; $display("FAIL copy3_error: got %b want 0", a_error); end
    checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL copy3_valid_fin: got %b want 0", a_valid); end
    tick();
    tick();
    checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL copy3_done_width: got %b want 0", a_done); end
    checks++; if (a_done_total - d0 !== 1) begin errors++; $display("FAIL copy3_done_count: got %0d want 1", a_done_total - d0); end
    checks++; if (a_cmd_ready !== 1'b1 || a_busy !== 1'b0) begin errors++; $display("FAIL copy3_idle: got ready=%b busy=%b want 1/0", a_cmd_ready, a_busy); end
    checks++; if (log_n - base !== 6) begin errors++; $display("FAIL copy3_txn_count: got %0d want 6", log_n - base); end
    for (int i = 0; i < 6; i++) begin
      exp_data = 32'h0300_0000 + 32'(4 * (i / 2));
      exp_addr = (i % 2 == 0) ? exp_data : 32'h0300_0010 + 32'(4 * (i / 2));
      checks++; if (log_addr[base+i] !== exp_addr) begin errors++; $display("FAIL copy3_addr[%0d]: got %h want %h", i, log_addr[base+i], exp_addr); end
      checks++; if (log_wstrb[base+i] !== ((i % 2 == 0) ? 4'h0 : 4'hF)) begin errors++; $display("FAIL copy3_wstrb[%0d]: got %h want %h", i, log_wstrb[base+i], (i % 2 == 0) ? 4'h0 : 4'hF); end
      if (i % 2 == 1) begin
        checks++; if (log_wdata[base+i] !== exp_data) begin errors++; $display("FAIL copy3_wdata[%0d]: got %h want %h", i, log_wdata[base+i], exp_data); end
      end
    end
  endtask

  task automatic test_len0();
    int vc0, d0;
    vc0 = a_valid_cycles;
    d0 = a_done_total;
    issue(1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 16'd0);
    // Done is seen in the cycle after the accept cycle (the second cycle counting accept).
    checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL len0_done: got %b want 1", a_done); end
    checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL len0_valid: got %b want 0", a_valid); end
    checks++; if (a_words !== 16'd0) begin errors++; $display("FAIL len0_words: got %0d want 0", a_words); end
    tick();
    checks++; if (a_done !== 1'b0 || a_cmd_ready !== 1'b1) begin errors++; $display("FAIL len0_after: got done=%b ready=%b want 0/1", a_done, a_cmd_ready); end
    tick();
    tick();
    checks++; if (a_valid_cycles - vc0 !== 0) begin errors++; $display("FAIL len0_no_bus: got %0d valid cycles want 0", a_valid_cycles - vc0); end
    checks++; if (a_done_total - d0 !== 1) begin errors++; $display("FAIL len0_done_count: got %0d want 1", a_done_total - d0); end
  endtask

  task automatic test_stall();
    int cyc, base, s0, sc0;
    bit ok;
    a_stall = 5;
    base = log_n;
    s0 = stab_err;
    sc0 = stab_cycles;
    issue(1'b0, 32'h1000_0000, 32'h2000_0040, 16'd2);
    wait_done_a(200, cyc, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_timeout: got no done want done within 200 cycles"); end
    // Each transaction: 1 request cycle + 1 latency + 5 stall cycles = 7; 4 transactions.
    checks++; if (cyc !== 28) begin errors++; $display("FAIL stall_latency: got %0d want 28", cyc); end
    checks++; if (stab_err !== s0) begin errors++; $display("FAIL stall_stable: got %0d unstable cycles want 0", stab_err - s0); end
    checks++; if (!(stab_cycles - sc0 >= 20)) begin errors++; $display("FAIL stall_monitored: got %0d held cycles want at least 20", stab_cycles - sc0); end
    checks++; if (a_words !== 16'd2 || a_error !== 1'b0) begin errors++; $display("FAIL stall_status: got words=%0d error=%b want 2/0", a_words, a_error); end
    checks++; if (log_n - base !== 4) begin errors++; $display("FAIL stall_txn_count: got %0d want 4", log_n - base); end
    checks++; if (log_addr[base+1] !== 32'h2000_0040 || log_wdata[base+1] !== 32'h1000_0000) begin errors++; $display("FAIL stall_wr0: got %h/%h want 20000040/10000000", log_addr[base+1], log_wdata[base+1]); end
    checks++; if (log_addr[base+3] !== 32'h2000_0044 || log_wdata[base+3] !== 32'h1000_0004) begin errors++; $display("FAIL stall_wr1: got %h/%h want 20000044/10000004", log_addr[base+3], log_wdata[base+3]); end
    a_stall = 0;
    tick();
    tick();
  endtask

  task automatic test_wrap();
    int cyc, base;
    bit ok;
    base = log_n;
    // Low address bits set on purpose: they must be ignored.
    issue(1'b0, 32'hFFFF_FFFE, 32'h0300_0103, 16'd2);
    wait_done_a(100, cyc, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_timeout: got no done want done within 100 cycles"); end
    checks++; if (log_addr[base] !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_rd0: got %h want fffffffc", log_addr[base]); end
    checks++; if (log_addr[base+1] !== 32'h0300_0100 || log_wdata[base+1] !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_wr0: got %h/%h want 03000100/fffffffc", log_addr[base+1], log_wdata[base+1]); end
    checks++; if (log_addr[base+2] !== 32'h0000_0000) begin errors++; $display("FAIL wrap_rd1: got %h want 00000000", log_addr[base+2]); end
    checks++; if (log_addr[base+3] !== 32'h0300_0104 || log_wdata[base+3] !== 32'h0000_0000) begin errors++; $display("FAIL wrap_wr1: got %h/%h want 03000104/00000000", log_addr[base+3], log_wdata[base+3]); end
    tick();
    tick();
  endtask

  task automatic test_timeout();
    int n, db0;
    bit found;
    b_limit = 2;
    db0 = b_done_total;
    issue(1'b1, 32'h0000_0040, 32'h0000_0080, 16'd3);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (b_valid && b_wstrb == 4'h0 && b_addr == 32'h0000_0044) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    checks++; if (!found) begin errors++; $display("FAIL timeout_second_read: got none want read of 00000044"); end
    n = 0;
    while (b_valid && n < 50) begin
      n++;
      tick();
    end
    checks++; if (n !== 8) begin errors++; $display("FAIL timeout_wait_cycles: got %0d want 8", n); end
    checks++; if (b_done !== 1'b1) begin errors++; $display("FAIL timeout_done: got %b want 1", b_done); end
    checks++; if (b_error !== 1'b1) begin errors++; $display("FAIL timeout_error: got %b want 1", b_error); end
    checks++; if (b_words !== 16'd1) begin errors++; $display("FAIL timeout_words: got %0d want 1", b_words); end
    tick();
    checks++; if (b_done !== 1'b0 || b_error !== 1'b1 || b_cmd_ready !== 1'b1) begin errors++; $display("FAIL timeout_after: got done=%b error=%b ready=%b want 0/1/1", b_done, b_error, b_cmd_ready); end
    tick();
    checks++; if (b_done_total - db0 !== 1) begin errors++; $display("FAIL timeout_done_count: got %0d want 1", b_done_total - db0); end
    b_limit = 100;
    issue(1'b1, 32'h0000_0100, 32'h0000_0200, 16'd0);
    checks++; if (b_error !== 1'b0) begin errors++; $display("FAIL timeout_error_clear: got %b want 0", b_error); end
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    int base, d0;
    bit found;
    a_stall = 0;
    base = log_n;
    d0 = a_done_total;
    issue(1'b0, 32'h0300_0000, 32'h0300_0040, 16'd4);
    // A second command held while busy must be ignored.
    cmd_src = 32'h0500_0000;
    cmd_dst = 32'h0500_0100;
    cmd_len = 16'd1;
    a_cmd_valid = 1'b1;
    checks++; if (a_cmd_ready !== 1'b0) begin errors++; $display("FAIL mid_cmd_ready_busy: got %b want 0", a_cmd_ready); end
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (a_valid && a_wstrb == 4'hF) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    checks++; if (!found) begin errors++; $display("FAIL mid_wr_seen: got none want a write request"); end
    checks++; if (a_addr !== 32'h0300_0040) begin errors++; $display("FAIL mid_wr_addr: got %h want 03000040", a_addr); end
    reset = 1'b1;
    a_cmd_valid = 1'b0;
    tick();
    checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL mid_valid_drop: got %b want 0", a_valid); end
    checks++; if (a_cmd_ready !== 1'b1 || a_busy !== 1'b0) begin errors++; $display("FAIL mid_idle: got ready=%b busy=%b want 1/0", a_cmd_ready, a_busy); end
    reset = 1'b0;
    tick();
    tick();
    tick();
    checks++; if (a_done_total - d0 !== 0) begin errors++; $display("FAIL mid_no_done: got %0d pulses want 0", a_done_total - d0); end
    checks++; if (log_n - base !== 1) begin errors++; $display("FAIL mid_txn_count: got %0d want 1", log_n - base); end
    checks++; if (log_addr[base] !== 32'h0300_0000) begin errors++; $display("FAIL mid_first_read: got %h want 03000000", log_addr[base]); end
    checks++; if (a_words !== 16'd0 || a_valid !== 1'b0) begin errors++; $display("FAIL mid_after: got words=%0d valid=%b want 0/0", a_words, a_valid); end
  endtask

  initial begin
    reset = 1'b1;
    a_cmd_valid = 1'b0;
    b_cmd_valid = 1'b0;
    cmd_src = 32'h0;
    cmd_dst = 32'h0;
    cmd_len = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_copy3();
    test_len0();
    test_stall();
    test_wrap();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200us");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/iomem_copy_master.md
Name: iomem_copy_master

Overview:
- Bus initiator for the iomem valid/ready peripheral interface. It is the master-side counterpart to the memory-mapped responders, such as the GPIO register, that hang off that bus.
- Accepts one copy command (source address, destination address, word count). For each word it performs a 32-bit read from the source, then a full-word write to the destination.
- Used for sensor-buffer to peripheral moves and as the bus driver in responder testbenches.
- Reports completion, word progress and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 256: maximum cycles a transaction may wait for iomem_ready before it is aborted. Must be ≥1.
- LEN_WIDTH, 16: width of the word-count field.

Ports:
- clk  input  1  single clock for all logic.
- reset  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  block can accept a command (high only in IDLE).
- cmd_src  input  32  source byte address. Bits [1:0] are ignored and treated as 0.
- cmd_dst  input  32  destination byte address. Bits [1:0] are ignored and treated as 0.
- cmd_len  input  LEN_WIDTH  number of 32-bit words to copy.
- done  output  1  one-cycle pulse when a command finishes, whether successfully or by abort.
- error  output  1  sticky: the last command aborted on timeout. Cleared when the next command is accepted.
- words_done  output  LEN_WIDTH  words fully written for the current or last command.
- busy  output  1  high whenever the state is not IDLE.
- iomem_valid  output  1  transaction request.
- iomem_ready  input  1  single-cycle responder acknowledge.
- iomem_wstrb  output  4  byte strobes. 4'b0000 means a read; 4'b1111 means a write.
- iomem_addr  output  32  transaction address.
- iomem_wdata  output  32  write data.
- iomem_rdata  input  32  read data, valid in the cycle iomem_ready is high.

Behaviour:
- Reset values (synchronous reset; a reset mid-transfer drops iomem_valid in the very next cycle, with no completion of the in-flight transfer and no done pulse):
  - state = IDLE, cmd_ready = 1, busy = 0, done = 0, error = 0, words_done = 0.
  - iomem_valid = 0, iomem_wstrb = 0, iomem_addr = 0, iomem_wdata = 0.
- States: IDLE, RD, WR, FIN.
- IDLE:
  - Command accepted when cmd_valid && cmd_ready.
  - On accept: latch src, dst and len; clear error and words_done; clear the timeout counter.
  - If len == 0, go to FIN. Otherwise go to RD.
  - cmd_valid while not in IDLE is ignored. There is no queueing.
- RD:
  - iomem_valid = 1, wstrb = 0, addr = cur_src.
  - On iomem_ready: capture iomem_rdata into the data register, cur_src += 4, go to WR.
- WR:
  - iomem_valid = 1, wstrb = 4'hF, addr = cur_dst, wdata = data register.
  - On iomem_ready: cur_dst += 4, words_done += 1.
  - If words_done + 1 == len, go to FIN. Otherwise go to RD.
- FIN: done = 1 for exactly one cycle, cmd_ready = 0, then return to IDLE.
- Handshake rules:
  - All iomem outputs are registered.
  - Once valid is asserted, addr, wstrb and wdata remain stable until the cycle iomem_ready is sampled high.
  - iomem_valid is low in FIN and IDLE.
  - Back-to-back issue is legal: a new transaction may be presented in the cycle immediately after ready. The responder ignores valid while its own ready is high.
  - A transaction is 1 request cycle plus responder latency. With a 1-cycle-latency responder, each word takes 4 cycles.
- Address arithmetic: 32-bit with natural wrap, so 32'hFFFFFFFC + 4 = 32'h0.
- Timeout:
  - The counter increments each cycle in RD or WR without ready, and resets to 0 on ready.
  - When the counter reaches TIMEOUT_CYCLES - 1 without ready: set error = 1, deassert valid next cycle, go to FIN.
  - words_done keeps the count of completed words.
- iomem_ready while not in RD or WR is ignored.

Test Plan:
- Copy len=3, src=32'h0300_0000 to dst=32'h0300_0010, using a 1-cycle model responder that returns the address as data. Required: reads of 0x..00, 0x..04, 0x..08 alternate with writes of that data to 0x..10, 0x..14, 0x..18; done pulses once; words_done=3; error=0; 12 cycles from accept to done-1.
- len=0 → no iomem_valid ever; done pulses 2 cycles after accept; words_done=0.
- Responder stalls 5 cycles per transfer with TIMEOUT_CYCLES=256 → addr, wstrb and wdata stable throughout each stall; the copy completes correctly.
- Responder never answers the second read with TIMEOUT_CYCLES=8 → error=1 and words_done=1; valid drops after 8 wait cycles; single done. The next accepted command clears error.
- src=32'hFFFF_FFFC, len=2 → second read at address 0x0000_0000.
- Assert reset during a WR cycle → iomem_valid=0 and cmd_ready=1 next cycle; no write completes and no done pulse. cmd_valid held while busy is ignored.
